// File: rtl/seq_match_pkg.sv
// Shared state type and sizing/clamp helpers for the sequence match checker.
package seq_match_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } state_e;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 32'sd1);
  endfunction

  function automatic int clamp_len(input int len, input int max_len);
    int res;
    if (len == 32'sd0) begin
      res = 32'sd1;
    end else if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_store.sv
// Digit storage for one round: single write port, asynchronous read port.
module seq_store #(
  parameter int DIGIT_W = 4,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [DIGIT_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [DIGIT_W-1:0] rdata
);

  logic [DIGIT_W-1:0] mem_r [DEPTH];

  // Storage write; contents are only meaningful below the round length.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/seq_match_checker.sv
// Stores a generated digit round, then checks user entries in order,
// reporting per-digit matches, progress, pass/fail and idle timeout.
module seq_match_checker
  import seq_match_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int MAX_LEN     = 8,
  parameter int TIMEOUT_CYC = 0,
  localparam int LEN_W      = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [LEN_W-1:0]   seq_len,
  input  logic               load_valid,
  input  logic [DIGIT_W-1:0] load_digit,
  output logic               load_ready,
  input  logic               user_valid,
  input  logic [DIGIT_W-1:0] user_digit,
  output logic               user_ready,
  output logic               match_pulse,
  output logic               pass,
  output logic               fail,
  output logic               timed_out,
  output logic [LEN_W-1:0]   progress
);

  localparam int ADDR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [TMR_W-1:0] TMO_LAST_V = TMR_W'(TMO_LAST);

  state_e             state_r, state_nx;
  logic [LEN_W-1:0]   wr_ptr_r, wr_ptr_nx;
  logic [LEN_W-1:0]   len_r, len_nx;
  logic [LEN_W-1:0]   progress_r, progress_nx;
  logic [TMR_W-1:0]   timer_r, timer_nx;
  logic               match_r, match_nx;
  logic               pass_r, pass_nx;
  logic               fail_r, fail_nx;
  logic               timed_out_r, timed_out_nx;

  logic               load_acc_s, user_acc_s, tmo_hit_s, match_s;
  logic               we_s;
  logic [ADDR_W-1:0]  waddr_s;
  logic [DIGIT_W-1:0] rd_digit_s;
  logic [LEN_W-1:0]   len_clamped_s, prog_inc_s;

  seq_store #(
    .DIGIT_W (DIGIT_W),
    .DEPTH   (MAX_LEN),
    .ADDR_W  (ADDR_W)
  ) u_store (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (load_digit),
    .raddr (ADDR_W'(progress_r)),
    .rdata (rd_digit_s)
  );

  assign load_ready    = (state_r != CHECK);
  assign user_ready    = (state_r == CHECK);
  assign load_acc_s    = load_valid & load_ready;
  assign user_acc_s    = user_valid & user_ready;
  assign len_clamped_s = LEN_W'(clamp_len(int'(seq_len), MAX_LEN));
  assign prog_inc_s    = progress_r + LEN_W'(1);
  assign match_s       = (user_digit == rd_digit_s);
  // An entry in the expiry cycle takes precedence over the timeout.
  assign tmo_hit_s     = (TIMEOUT_CYC > 0) && user_ready && !user_acc_s &&
                         (timer_r == TMO_LAST_V);

  // Next-state and datapath control.
  always_comb begin
    state_nx     = state_r;
    wr_ptr_nx    = wr_ptr_r;
    len_nx       = len_r;
    progress_nx  = progress_r;
    timer_nx     = timer_r;
    match_nx     = 1'b0;
    pass_nx      = pass_r;
    fail_nx      = fail_r;
    timed_out_nx = timed_out_r;
    we_s         = 1'b0;
    waddr_s      = ADDR_W'(wr_ptr_r);
    if (clear) begin
      state_nx     = IDLE;
      wr_ptr_nx    = '0;
      len_nx       = '0;
      progress_nx  = '0;
      timer_nx     = '0;
      pass_nx      = 1'b0;
      fail_nx      = 1'b0;
      timed_out_nx = 1'b0;
    end else begin
      case (state_r)
        IDLE, PASS, FAIL: begin
          if (load_acc_s) begin
            we_s         = 1'b1;
            waddr_s      = '0;
            wr_ptr_nx    = LEN_W'(1);
            len_nx       = len_clamped_s;
            progress_nx  = '0;
            timer_nx     = '0;
            pass_nx      = 1'b0;
            fail_nx      = 1'b0;
            timed_out_nx = 1'b0;
            state_nx     = (len_clamped_s == LEN_W'(1)) ? CHECK : LOAD;
          end else begin
            state_nx = state_r;
          end
        end
        LOAD: begin
          if (load_acc_s) begin
            we_s      = 1'b1;
            wr_ptr_nx = wr_ptr_r + LEN_W'(1);
            if (wr_ptr_r == len_r - LEN_W'(1)) begin
              state_nx = CHECK;
              timer_nx = '0;
            end else begin
              state_nx = LOAD;
            end
          end else begin
            state_nx = LOAD;
          end
        end
        CHECK: begin
          if (user_acc_s) begin
            timer_nx = '0;
            if (match_s) begin
              match_nx    = 1'b1;
              progress_nx = prog_inc_s;
              if (prog_inc_s == len_r) begin
                state_nx = PASS;
                pass_nx  = 1'b1;
              end else begin
                state_nx = CHECK;
              end
            end else begin
              state_nx = FAIL;
              fail_nx  = 1'b1;
            end
          end else if (tmo_hit_s) begin
            state_nx     = FAIL;
            fail_nx      = 1'b1;
            timed_out_nx = 1'b1;
          end else if (TIMEOUT_CYC > 0) begin
            timer_nx = timer_r + TMR_W'(1);
          end else begin
            timer_nx = timer_r;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      wr_ptr_r    <= '0;
      len_r       <= '0;
      progress_r  <= '0;
      timer_r     <= '0;
      match_r     <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      timed_out_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      wr_ptr_r    <= wr_ptr_nx;
      len_r       <= len_nx;
      progress_r  <= progress_nx;
      timer_r     <= timer_nx;
      match_r     <= match_nx;
      pass_r      <= pass_nx;
      fail_r      <= fail_nx;
      timed_out_r <= timed_out_nx;
    end
  end

  assign match_pulse = match_r;
  assign pass        = pass_r;
  assign fail        = fail_r;
  assign timed_out   = timed_out_r;
  assign progress    = progress_r;

endmodule
